// File: rtl/exe_mem_issue_pkg.sv
// Shared definitions for the EXE->MEM memory-issue stage: access size codes,
// default sizing and the layout of the memory fields carried to MEM.
package exe_mem_issue_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam int DEFAULT_PAYLOAD_W = 256;
    localparam int DEFAULT_MAX_OUT   = 15;
    localparam int CNT_W             = 4;

    // Memory-related fields captured from EXE alongside the opaque payload.
    typedef struct packed {
        logic        mem_en;
        logic        we;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ex;
    } mem_req_t;

endpackage

// File: rtl/exe_mem_issue_if.sv
// Data SRAM address/response channel. The issue stage is the master; the
// memory side returns addr_ok (request taken) and data_ok (one response).
interface exe_mem_issue_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok
    );

endinterface

// File: rtl/exe_mem_issue_outstanding_cnt.sv
// Outstanding data SRAM transaction counter. Counts accepted requests that
// have not yet returned data_ok; guarded so it never wraps in either direction.
module exe_mem_issue_outstanding_cnt
    import exe_mem_issue_pkg::*;
#(
    parameter int MAX = DEFAULT_MAX_OUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    // Up on inc, down on dec, hold when both or neither; a stray dec at zero is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_W'(MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exe_mem_issue.sv
// Memory-issue stage between EXE and MEM. Holds one instruction, drives the
// data SRAM address phase for loads/stores, tells MEM whether a data phase is
// owed, and tracks outstanding transactions so MEM can drain after a flush.
module exe_mem_issue
    import exe_mem_issue_pkg::*;
#(
    parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
    parameter int MAX_OUT   = DEFAULT_MAX_OUT
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic                 in_mem_en,
    input  logic                 in_mem_we,
    input  logic [1:0]           in_size,
    input  logic [3:0]           in_wstrb,
    input  logic [31:0]          in_addr,
    input  logic [31:0]          in_wdata,
    input  logic                 in_ex,
    input  logic [PAYLOAD_W-1:0] in_payload,

    output logic                 out_valid,
    input  logic                 out_allowin,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_ex,
    output logic                 out_wait_data,

    exe_mem_issue_if.master      data_sram,

    input  logic                 flush,
    input  logic                 mem_block,
    output logic [CNT_W-1:0]     io_cnt
);

    mem_req_t             r;
    logic [PAYLOAD_W-1:0] payload_r;
    logic                 valid;
    logic                 req_sent;
    logic                 req;
    logic                 accept;
    logic                 ready_go;
    logic                 handoff;

    // Flush withdraws a pending request combinationally; a full counter or a
    // blocking older instruction simply holds the request back.
    assign req = valid && r.mem_en && !r.ex && !req_sent && !flush && !mem_block
                 && (io_cnt != CNT_W'(MAX_OUT));

    assign accept     = req && data_sram.addr_ok;
    assign ready_go   = !r.mem_en || r.ex || req_sent || accept;
    assign out_valid  = valid && ready_go;
    assign in_allowin = !valid || (ready_go && out_allowin);
    assign handoff    = out_valid && out_allowin;

    assign out_wait_data = r.mem_en && !r.ex && (req_sent || accept);
    assign out_payload   = payload_r;
    assign out_ex        = r.ex;

    assign data_sram.req   = req;
    assign data_sram.wr    = r.we;
    assign data_sram.size  = r.size;
    assign data_sram.wstrb = r.wstrb;
    assign data_sram.addr  = r.addr;
    assign data_sram.wdata = r.wdata;

    // Instruction registers; in_allowin is low while a request is pending, so
    // the address-phase fields cannot change under an un-acknowledged req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r         <= '0;
            payload_r <= '0;
        end else if (in_valid && in_allowin) begin
            r.mem_en  <= in_mem_en;
            r.we      <= in_mem_we;
            r.size    <= in_size;
            r.wstrb   <= in_wstrb;
            r.addr    <= in_addr;
            r.wdata   <= in_wdata;
            r.ex      <= in_ex;
            payload_r <= in_payload;
        end
    end

    // Stage occupancy; flush empties the stage regardless of handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (in_allowin) begin
            valid <= in_valid;
        end
    end

    // Remembers that this instruction's request was taken; freed on handoff or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_sent <= 1'b0;
        end else if (flush || handoff) begin
            req_sent <= 1'b0;
        end else if (accept) begin
            req_sent <= 1'b1;
        end
    end

    exe_mem_issue_outstanding_cnt #(
        .MAX (MAX_OUT)
    ) u_outstanding_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .dec   (data_sram.data_ok),
        .cnt   (io_cnt)
    );

endmodule

// File: tb/tb_exe_mem_issue.sv
// Self-checking bench for exe_mem_issue: scenario tasks drive stimulus and
// check SRAM/handshake outputs inline; a scoreboard checks every MEM handoff.
module tb_exe_mem_issue;
    import exe_mem_issue_pkg::*;

    localparam int PW = 256;

    typedef struct {
        logic [PW-1:0] payload;
        logic          ex;
        logic          wait_data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_allowin;
    logic          in_mem_en;
    logic          in_mem_we;
    logic [1:0]    in_size;
    logic [3:0]    in_wstrb;
    logic [31:0]   in_addr;
    logic [31:0]   in_wdata;
    logic          in_ex;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_allowin;
    logic [PW-1:0] out_payload;
    logic          out_ex;
    logic          out_wait_data;
    logic          flush;
    logic          mem_block;
    logic [3:0]    io_cnt;

    exe_mem_issue_if sram ();

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];

    exe_mem_issue #(
        .PAYLOAD_W (PW),
        .MAX_OUT   (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_allowin    (in_allowin),
        .in_mem_en     (in_mem_en),
        .in_mem_we     (in_mem_we),
        .in_size       (in_size),
        .in_wstrb      (in_wstrb),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_ex         (in_ex),
        .in_payload    (in_payload),
        .out_valid     (out_valid),
        .out_allowin   (out_allowin),
        .out_payload   (out_payload),
        .out_ex        (out_ex),
        .out_wait_data (out_wait_data),
        .data_sram     (sram),
        .flush         (flush),
        .mem_block     (mem_block),
        .io_cnt        (io_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk_payload(input logic [31:0] tag);
        return {8{tag}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_inst(input logic mem_en, input logic we, input logic [1:0] size,
                            input logic [3:0] wstrb, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic ex, input logic [31:0] tag);
        in_valid   = 1'b1;
        in_mem_en  = mem_en;
        in_mem_we  = we;
        in_size    = size;
        in_wstrb   = wstrb;
        in_addr    = addr;
        in_wdata   = wdata;
        in_ex      = ex;
        in_payload = mk_payload(tag);
    endtask

    task automatic push_exp(input logic [31:0] tag, input logic ex, input logic wait_data);
        exp_t e;
        e.payload   = mk_payload(tag);
        e.ex        = ex;
        e.wait_data = wait_data;
        sb.push_back(e);
    endtask

    // Scoreboard: every accepted handoff to MEM must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_allowin) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL handoff_unexpected got payload=%h required no handoff", out_payload[31:0]);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_payload !== e.payload || out_ex !== e.ex || out_wait_data !== e.wait_data) begin
                    miscompares++;
                    $display("[TB] FAIL handoff got tag=%h ex=%0b wait=%0b required tag=%h ex=%0b wait=%0b",
                             out_payload[31:0], out_ex, out_wait_data, e.payload[31:0], e.ex, e.wait_data);
                end
            end
        end
    end

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid got=%0b required=0", out_valid); end
        vectors++; if (out_wait_data !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait_data got=%0b required=0", out_wait_data); end
        vectors++; if (out_ex !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_ex got=%0b required=0", out_ex); end
        vectors++; if (out_payload !== '0) begin miscompares++; $display("[TB] FAIL rst_payload got=%h required=0", out_payload); end
        vectors++; if (sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req got=%0b required=0", sram.req); end
        vectors++; if ({sram.wr, sram.size, sram.wstrb} !== 7'd0) begin miscompares++; $display("[TB] FAIL rst_ctl got=%h required=0", {sram.wr, sram.size, sram.wstrb}); end
        vectors++; if (sram.addr !== 32'd0 || sram.wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_addr_data got=%h/%h required=0/0", sram.addr, sram.wdata); end
        vectors++; if (in_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_allowin got=%0b required=1", in_allowin); end
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_io_cnt got=%0d required=0", io_cnt); end
    endtask

    task automatic test_load();
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0000_1000, 32'h0, 1'b0, 32'hA100_0001);
        #1;
        vectors++; if (in_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL load_allowin got=%0b required=1", in_allowin); end
        push_exp(32'hA100_0001, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        vectors++; if (sram.req !== 1'b1) begin miscompares++; $display("[TB] FAIL load_req got=%0b required=1", sram.req); end
        vectors++; if (sram.addr !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL load_addr got=%h required=00001000", sram.addr); end
        vectors++; if (sram.size !== 2'd2 || sram.wr !== 1'b0) begin miscompares++; $display("[TB] FAIL load_size_wr got=%0d/%0b required=2/0", sram.size, sram.wr); end
        sram.addr_ok = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b1 || out_wait_data !== 1'b1) begin miscompares++; $display("[TB] FAIL load_same_cycle_out got=%0b/%0b required=1/1", out_valid, out_wait_data); end
        tick();
        sram.addr_ok = 1'b0;
        #1;
        vectors++; if (io_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL load_io_cnt_up got=%0d required=1", io_cnt); end
        vectors++; if (sram.req !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_drained got req=%0b out=%0b required 0/0", sram.req, out_valid); end
        sram.data_ok = 1'b1;
        tick();
        sram.data_ok = 1'b0;
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL load_io_cnt_down got=%0d required=0", io_cnt); end
    endtask

    task automatic test_store_delayed();
        set_inst(1'b1, 1'b1, SZ_H, 4'h3, 32'h0000_2004, 32'h0000_BEEF, 1'b0, 32'hA200_0002);
        #1;
        vectors++; if (in_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL st_allowin_idle got=%0b required=1", in_allowin); end
        push_exp(32'hA200_0002, 1'b0, 1'b1);
        tick();
        set_inst(1'b0, 1'b0, SZ_W, 4'h0, 32'h0000_3000, 32'h0000_1234, 1'b0, 32'hA200_0003);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (sram.req !== 1'b1) begin miscompares++; $display("[TB] FAIL st_req_hold[%0d] got=%0b required=1", i, sram.req); end
            vectors++; if (sram.addr !== 32'h0000_2004 || sram.wdata !== 32'h0000_BEEF) begin miscompares++; $display("[TB] FAIL st_stable[%0d] got=%h/%h required=00002004/0000beef", i, sram.addr, sram.wdata); end
            vectors++; if (sram.wr !== 1'b1 || sram.wstrb !== 4'h3 || sram.size !== 2'd1) begin miscompares++; $display("[TB] FAIL st_ctl[%0d] got=%0b/%h/%0d required=1/3/1", i, sram.wr, sram.wstrb, sram.size); end
            vectors++; if (in_allowin !== 1'b0) begin miscompares++; $display("[TB] FAIL st_allowin_stall[%0d] got=%0b required=0", i, in_allowin); end
            tick();
        end
        sram.addr_ok = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b1 || in_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL st_accept got req=%0b allowin=%0b required 1/1", sram.req, in_allowin); end
        push_exp(32'hA200_0003, 1'b0, 1'b0);
        tick();
        sram.addr_ok = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++; if (io_cnt !== 4'd1 || sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL st_after got cnt=%0d req=%0b required 1/0", io_cnt, sram.req); end
        tick();
        sram.data_ok = 1'b1;
        tick();
        sram.data_ok = 1'b0;
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL st_drain got=%0d required=0", io_cnt); end
    endtask

    task automatic test_flush_pending();
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0000_4000, 32'h0, 1'b0, 32'hA300_0004);
        tick();
        in_valid = 1'b0;
        #1;
        vectors++; if (sram.req !== 1'b1) begin miscompares++; $display("[TB] FAIL fp_req got=%0b required=1", sram.req); end
        flush = 1'b1;
        sram.addr_ok = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fp_withdraw got req=%0b out=%0b required 0/0", sram.req, out_valid); end
        tick();
        flush = 1'b0;
        sram.addr_ok = 1'b0;
        #1;
        vectors++; if (in_allowin !== 1'b1 || out_valid !== 1'b0 || sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL fp_empty got allowin=%0b out=%0b req=%0b required 1/0/0", in_allowin, out_valid, sram.req); end
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL fp_io_cnt got=%0d required=0", io_cnt); end
    endtask

    task automatic test_flush_accepted();
        out_allowin = 1'b0;
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0000_5000, 32'h0, 1'b0, 32'hA400_0005);
        tick();
        in_valid = 1'b0;
        sram.addr_ok = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b1) begin miscompares++; $display("[TB] FAIL fa_req got=%0b required=1", sram.req); end
        tick();
        sram.addr_ok = 1'b0;
        #1;
        vectors++; if (io_cnt !== 4'd1 || out_valid !== 1'b1 || out_wait_data !== 1'b1 || sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL fa_held got cnt=%0d out=%0b wait=%0b req=%0b required 1/1/1/0", io_cnt, out_valid, out_wait_data, sram.req); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_wait_data !== 1'b0) begin miscompares++; $display("[TB] FAIL fa_flushed got out=%0b wait=%0b required 0/0", out_valid, out_wait_data); end
        vectors++; if (io_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL fa_cnt_kept got=%0d required=1", io_cnt); end
        tick();
        tick();
        vectors++; if (io_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL fa_cnt_wait got=%0d required=1", io_cnt); end
        sram.data_ok = 1'b1;
        tick();
        sram.data_ok = 1'b0;
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL fa_cnt_drain got=%0d required=0", io_cnt); end
        out_allowin = 1'b1;
    endtask

    task automatic test_full();
        for (int i = 0; i < 15; i++) begin
            set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0001_0000 + 32'(i * 4), 32'h0, 1'b0, 32'hA500_0000 + 32'(i));
            push_exp(32'hA500_0000 + 32'(i), 1'b0, 1'b1);
            tick();
            in_valid = 1'b0;
            sram.addr_ok = 1'b1;
            tick();
            sram.addr_ok = 1'b0;
        end
        vectors++; if (io_cnt !== 4'd15) begin miscompares++; $display("[TB] FAIL full_cnt got=%0d required=15", io_cnt); end
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0002_0000, 32'h0, 1'b0, 32'hA500_0010);
        push_exp(32'hA500_0010, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        sram.addr_ok = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b0 || in_allowin !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_stall got req=%0b allowin=%0b out=%0b required 0/0/0", sram.req, in_allowin, out_valid); end
        tick();
        vectors++; if (io_cnt !== 4'd15 || sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL full_no_overflow got cnt=%0d req=%0b required 15/0", io_cnt, sram.req); end
        sram.data_ok = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL full_req_during_dok got=%0b required=0", sram.req); end
        tick();
        vectors++; if (io_cnt !== 4'd14 || sram.req !== 1'b1) begin miscompares++; $display("[TB] FAIL full_reissue got cnt=%0d req=%0b required 14/1", io_cnt, sram.req); end
        tick();
        sram.data_ok = 1'b0;
        sram.addr_ok = 1'b0;
        #1;
        vectors++; if (io_cnt !== 4'd14) begin miscompares++; $display("[TB] FAIL full_inc_dec_same got=%0d required=14", io_cnt); end
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0002_0004, 32'h0, 1'b0, 32'hA500_0011);
        push_exp(32'hA500_0011, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        sram.addr_ok = 1'b1;
        tick();
        sram.addr_ok = 1'b0;
        #1;
        vectors++; if (io_cnt !== 4'd15) begin miscompares++; $display("[TB] FAIL full_refill got=%0d required=15", io_cnt); end
        sram.data_ok = 1'b1;
        repeat (15) tick();
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL full_drain got=%0d required=0", io_cnt); end
        tick();
        sram.data_ok = 1'b0;
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL underflow_guard got=%0d required=0", io_cnt); end
    endtask

    task automatic test_ex_block();
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0000_6000, 32'h0, 1'b1, 32'hA600_0020);
        push_exp(32'hA600_0020, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        sram.addr_ok = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b0) begin miscompares++; $display("[TB] FAIL ex_no_req got=%0b required=0", sram.req); end
        vectors++; if (out_valid !== 1'b1 || out_ex !== 1'b1 || out_wait_data !== 1'b0) begin miscompares++; $display("[TB] FAIL ex_pass got out=%0b ex=%0b wait=%0b required 1/1/0", out_valid, out_ex, out_wait_data); end
        tick();
        sram.addr_ok = 1'b0;
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL ex_cnt got=%0d required=0", io_cnt); end
        mem_block = 1'b1;
        set_inst(1'b0, 1'b0, SZ_W, 4'h0, 32'h0000_7000, 32'h0, 1'b0, 32'hA600_0021);
        push_exp(32'hA600_0021, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL blk_nonmem_advance got=%0b required=1", out_valid); end
        tick();
        set_inst(1'b1, 1'b0, SZ_B, 4'h1, 32'h0000_7001, 32'h0, 1'b0, 32'hA600_0022);
        push_exp(32'hA600_0022, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        sram.addr_ok = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (sram.req !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL blk_stall[%0d] got req=%0b out=%0b required 0/0", i, sram.req, out_valid); end
            tick();
        end
        mem_block = 1'b0;
        #1;
        vectors++; if (sram.req !== 1'b1 || sram.size !== 2'd0) begin miscompares++; $display("[TB] FAIL blk_release got req=%0b size=%0d required 1/0", sram.req, sram.size); end
        tick();
        sram.addr_ok = 1'b0;
        #1;
        vectors++; if (io_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL blk_cnt got=%0d required=1", io_cnt); end
        sram.data_ok = 1'b1;
        tick();
        sram.data_ok = 1'b0;
        vectors++; if (io_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL blk_drain got=%0d required=0", io_cnt); end
    endtask

    task automatic test_reset_mid();
        set_inst(1'b1, 1'b0, SZ_W, 4'hF, 32'h0000_8000, 32'h0, 1'b0, 32'hA700_0030);
        push_exp(32'hA700_0030, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        sram.addr_ok = 1'b1;
        tick();
        sram.addr_ok = 1'b0;
        set_inst(1'b1, 1'b1, SZ_W, 4'hF, 32'h0000_8004, 32'hCAFE_F00D, 1'b0, 32'hA700_0031);
        tick();
        in_valid = 1'b0;
        #1;
        vectors++; if (sram.req !== 1'b1 || io_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL rm_pending got req=%0b cnt=%0d required 1/1", sram.req, io_cnt); end
        reset = 1'b1;
        #1;
        vectors++; if (sram.req !== 1'b0 || out_valid !== 1'b0 || out_wait_data !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_async_clear got req=%0b out=%0b wait=%0b required 0/0/0", sram.req, out_valid, out_wait_data); end
        vectors++; if (io_cnt !== 4'd0 || in_allowin !== 1'b1 || sram.addr !== 32'd0 || sram.wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rm_state got cnt=%0d allowin=%0b addr=%h wdata=%h required 0/1/0/0", io_cnt, in_allowin, sram.addr, sram.wdata); end
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        in_mem_en    = 1'b0;
        in_mem_we    = 1'b0;
        in_size      = 2'd0;
        in_wstrb     = 4'd0;
        in_addr      = 32'd0;
        in_wdata     = 32'd0;
        in_ex        = 1'b0;
        in_payload   = '0;
        out_allowin  = 1'b1;
        flush        = 1'b0;
        mem_block    = 1'b0;
        sram.addr_ok = 1'b0;
        sram.data_ok = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        test_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_load();
        test_store_delayed();
        test_flush_pending();
        test_flush_accepted();
        test_full();
        test_ex_block();
        test_reset_mid();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_leftover got=%0d entries required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
